// File: rtl/rx_cmd_pkg.sv
// Shared constants and state encoding for the UART RX command decoder.
// The optional inter-byte timeout is enabled with RX_CMD_TIMEOUT_EN.
package rx_cmd_pkg;

    localparam logic [7:0] OP_RF_WR   = 8'hAA;
    localparam logic [7:0] OP_RF_RD   = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    localparam int unsigned ADDR_OPA = 32'd0;
    localparam int unsigned ADDR_OPB = 32'd1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ADDR  = 3'd1,
        ST_WR_DATA  = 3'd2,
        ST_RD_ADDR  = 3'd3,
        ST_ALU_A    = 3'd4,
        ST_ALU_B    = 3'd5,
        ST_ALU_FUN  = 3'd6,
        ST_WAIT_RSP = 3'd7
    } state_e;

    // States that are partway through collecting a command's bytes.
    function automatic logic is_collecting(state_e s);
        logic r;
        case (s)
            ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
            ST_ALU_A, ST_ALU_B, ST_ALU_FUN: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rx_cmd_decoder_if.sv
// Byte-stream input and register-file / ALU command bus of rx_cmd_decoder.
// The decoder sits on the slave side; the stream source and consumers on the master side.
interface rx_cmd_decoder_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned FUNC_W = 4
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rsp_done;
    logic              rf_wr_en;
    logic              rf_rd_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              alu_en;
    logic [FUNC_W-1:0] alu_fun;
    logic              cmd_err;
    logic              overrun;
    logic              timeout;

    modport master (
        output rx_data, rx_valid, rsp_done,
        input  rf_wr_en, rf_rd_en, rf_addr, rf_wdata, alu_en, alu_fun,
               cmd_err, overrun, timeout
    );

    modport slave (
        input  rx_data, rx_valid, rsp_done,
        output rf_wr_en, rf_rd_en, rf_addr, rf_wdata, alu_en, alu_fun,
               cmd_err, overrun, timeout
    );
endinterface

// File: rtl/rx_cmd_timeout_cnt.sv
// Inter-byte idle counter; expired flags the last idle cycle before a command is aborted.
// Only instantiated when RX_CMD_TIMEOUT_EN is defined.
module rx_cmd_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 32'd1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: load zero on clear, otherwise advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/rx_cmd_decoder.sv
// Parses the received UART byte stream into register-file and ALU command strobes.
// Define RX_CMD_TIMEOUT_EN to abort partial commands after TIMEOUT_CYC idle cycles.
module rx_cmd_decoder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned FUNC_W = 4
`ifdef RX_CMD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst,
    rx_cmd_decoder_if.slave  bus
);
    import rx_cmd_pkg::*;

    state_e            state_d,    state_q;
    logic              rf_wr_en_d, rf_wr_en_q;
    logic              rf_rd_en_d, rf_rd_en_q;
    logic [ADDR_W-1:0] rf_addr_d,  rf_addr_q;
    logic [DATA_W-1:0] rf_wdata_d, rf_wdata_q;
    logic              alu_en_d,   alu_en_q;
    logic [FUNC_W-1:0] alu_fun_d,  alu_fun_q;
    logic              cmd_err_d,  cmd_err_q;
    logic              overrun_d,  overrun_q;
    logic              timeout_d,  timeout_q;
    logic              expired_s;

`ifdef RX_CMD_TIMEOUT_EN
    logic collect_s;
    logic cnt_clr_s;

    assign collect_s = is_collecting(state_q);
    assign cnt_clr_s = bus.rx_valid || !collect_s;

    rx_cmd_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr_s),
        .en      (collect_s),
        .expired (expired_s)
    );
`else
    assign expired_s = 1'b0;
`endif

    // Next-state and next-output decode; strobes default low, data fields hold.
    always_comb begin
        state_d    = state_q;
        rf_wr_en_d = 1'b0;
        rf_rd_en_d = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        alu_en_d   = 1'b0;
        alu_fun_d  = alu_fun_q;
        cmd_err_d  = 1'b0;
        overrun_d  = 1'b0;
        timeout_d  = 1'b0;

        if (state_q == ST_WAIT_RSP) begin
            // A byte arriving together with rsp_done is still dropped.
            overrun_d = bus.rx_valid;
            state_d   = bus.rsp_done ? ST_IDLE : ST_WAIT_RSP;
        end else if (bus.rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    case (bus.rx_data)
                        OP_RF_WR:   state_d = ST_WR_ADDR;
                        OP_RF_RD:   state_d = ST_RD_ADDR;
                        OP_ALU_OP:  state_d = ST_ALU_A;
                        OP_ALU_NOP: state_d = ST_ALU_FUN;
                        default: begin
                            state_d   = ST_IDLE;
                            cmd_err_d = 1'b1;
                        end
                    endcase
                end
                ST_WR_ADDR: begin
                    rf_addr_d = bus.rx_data[ADDR_W-1:0];
                    state_d   = ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    rf_wdata_d = bus.rx_data;
                    rf_wr_en_d = 1'b1;
                    state_d    = ST_IDLE;
                end
                ST_RD_ADDR: begin
                    rf_addr_d  = bus.rx_data[ADDR_W-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = ST_WAIT_RSP;
                end
                ST_ALU_A: begin
                    rf_addr_d  = ADDR_W'(ADDR_OPA);
                    rf_wdata_d = bus.rx_data;
                    rf_wr_en_d = 1'b1;
                    state_d    = ST_ALU_B;
                end
                ST_ALU_B: begin
                    rf_addr_d  = ADDR_W'(ADDR_OPB);
                    rf_wdata_d = bus.rx_data;
                    rf_wr_en_d = 1'b1;
                    state_d    = ST_ALU_FUN;
                end
                ST_ALU_FUN: begin
                    alu_fun_d = bus.rx_data[FUNC_W-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = ST_WAIT_RSP;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (expired_s) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rf_wr_en_q <= 1'b0;
            rf_rd_en_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            alu_en_q   <= 1'b0;
            alu_fun_q  <= '0;
            cmd_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_rd_en_q <= rf_rd_en_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            alu_en_q   <= alu_en_d;
            alu_fun_q  <= alu_fun_d;
            cmd_err_q  <= cmd_err_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.rf_wr_en = rf_wr_en_q;
    assign bus.rf_rd_en = rf_rd_en_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.alu_en   = alu_en_q;
    assign bus.alu_fun  = alu_fun_q;
    assign bus.cmd_err  = cmd_err_q;
    assign bus.overrun  = overrun_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Self-checking bench for rx_cmd_decoder: directed scenarios plus random byte streams
// compared against a command-length based reference model.
module tb_rx_cmd_decoder;

    localparam int TO_CYC = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    rx_cmd_decoder_if #(.DATA_W(8), .ADDR_W(4), .FUNC_W(4)) bus ();

    rx_cmd_decoder #(
        .DATA_W (8),
        .ADDR_W (4),
        .FUNC_W (4)
`ifdef RX_CMD_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TO_CYC)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] m_cmd[$];
    bit         m_wait;
    int         m_idle;
    logic [3:0] m_addr;
    logic [7:0] m_wdata;
    logic [3:0] m_fun;
    bit         e_wr, e_rd, e_alu, e_err, e_ovr, e_to;

    function automatic int cmd_len(logic [7:0] op);
        case (op)
            8'hAA:   return 3;
            8'hBB:   return 2;
            8'hCC:   return 4;
            8'hDD:   return 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_cmd.delete();
        m_wait = 0; m_idle = 0;
        m_addr = 4'h0; m_wdata = 8'h00; m_fun = 4'h0;
        {e_wr, e_rd, e_alu, e_err, e_ovr, e_to} = 6'b0;
    endtask

    task automatic model_step(bit v, logic [7:0] d, bit r);
        int pos;
        logic [7:0] op;
        {e_wr, e_rd, e_alu, e_err, e_ovr, e_to} = 6'b0;
        if (m_wait) begin
            e_ovr = v;
            if (r) m_wait = 0;
        end else if (v) begin
            m_idle = 0;
            m_cmd.push_back(d);
            pos = m_cmd.size() - 1;
            op  = m_cmd[0];
            if (pos == 0) begin
                if (cmd_len(op) == 0) begin
                    e_err = 1;
                    m_cmd.delete();
                end
            end else begin
                case (op)
                    8'hAA: if (pos == 1) m_addr = d[3:0];
                           else begin m_wdata = d; e_wr = 1; end
                    8'hBB: begin m_addr = d[3:0]; e_rd = 1; end
                    8'hCC: if (pos < 3) begin m_addr = 4'(pos - 1); m_wdata = d; e_wr = 1; end
                           else begin m_fun = d[3:0]; e_alu = 1; end
                    8'hDD: begin m_fun = d[3:0]; e_alu = 1; end
                    default: ;
                endcase
                if (m_cmd.size() == cmd_len(op)) begin
                    m_wait = (op != 8'hAA);
                    m_cmd.delete();
                end
            end
        end else if (m_cmd.size() > 0) begin
            m_idle++;
`ifdef RX_CMD_TIMEOUT_EN
            if (m_idle == TO_CYC) begin
                e_to = 1;
                m_idle = 0;
                m_cmd.delete();
            end
`endif
        end
    endtask

    function automatic logic [21:0] expv();
        return {e_wr, e_rd, m_addr, m_wdata, e_alu, m_fun, e_err, e_ovr, e_to};
    endfunction

    function automatic logic [21:0] obs();
        return {bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wdata, bus.alu_en,
                bus.alu_fun, bus.cmd_err, bus.overrun, bus.timeout};
    endfunction

    // One clock: drive inputs, advance model, sample 1 time unit after the edge.
    task automatic cyc(bit v, logic [7:0] d, bit r);
        bus.rx_valid = v; bus.rx_data = d; bus.rsp_done = r;
        model_step(v, d, r);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0; bus.rsp_done = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs() !== 22'h0) $display("FAIL reset_hold: got %h expected %h", obs(), 22'h0);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (obs() !== expv()) $display("FAIL reset_release: got %h expected %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_write();
        logic [9:0] seq [3] = '{{1'b1, 8'hAA, 1'b0}, {1'b1, 8'h05, 1'b0}, {1'b1, 8'h3C, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            cyc(seq[i][9], seq[i][8:1], seq[i][0]);
            n_checks++;
            if (obs() !== expv()) $display("FAIL write[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if (bus.rf_wr_en !== 1'b1 || bus.rf_addr !== 4'h5 || bus.rf_wdata !== 8'h3C)
            $display("FAIL write_fields: got wr=%b addr=%h data=%h expected wr=1 addr=5 data=3c",
                     bus.rf_wr_en, bus.rf_addr, bus.rf_wdata);
        else n_pass++;
    endtask

    task automatic test_read_overrun();
        logic [9:0] seq [13] = '{
            {1'b1, 8'hBB, 1'b0}, {1'b1, 8'h07, 1'b0}, {1'b1, 8'hAA, 1'b0},
            {1'b0, 8'h00, 1'b1}, {1'b1, 8'hAA, 1'b0}, {1'b1, 8'h01, 1'b0},
            {1'b1, 8'h02, 1'b0}, {1'b1, 8'hBB, 1'b0}, {1'b1, 8'hF7, 1'b0},
            {1'b1, 8'hAA, 1'b1}, {1'b1, 8'hAA, 1'b0}, {1'b1, 8'h0E, 1'b0},
            {1'b1, 8'h77, 1'b0}};
        for (int i = 0; i < 13; i++) begin
            cyc(seq[i][9], seq[i][8:1], seq[i][0]);
            n_checks++;
            if (obs() !== expv()) $display("FAIL read[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
            if (i == 2) begin
                n_checks++;
                if (bus.overrun !== 1'b1) $display("FAIL read_overrun: got %b expected 1", bus.overrun);
                else n_pass++;
            end
        end
    endtask

    task automatic test_alu_back_to_back();
        logic [9:0] seq [5] = '{{1'b1, 8'hCC, 1'b0}, {1'b1, 8'h12, 1'b0}, {1'b1, 8'h34, 1'b0},
                                {1'b1, 8'h02, 1'b0}, {1'b0, 8'h00, 1'b1}};
        for (int i = 0; i < 5; i++) begin
            cyc(seq[i][9], seq[i][8:1], seq[i][0]);
            n_checks++;
            if (obs() !== expv()) $display("FAIL alu[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
            if (i == 3) begin
                n_checks++;
                if (bus.alu_en !== 1'b1 || bus.alu_fun !== 4'h2)
                    $display("FAIL alu_fun: got en=%b fun=%h expected en=1 fun=2", bus.alu_en, bus.alu_fun);
                else n_pass++;
            end
        end
    endtask

    task automatic test_alu_nop_cmd_err();
        logic [9:0] seq [4] = '{{1'b1, 8'hDD, 1'b0}, {1'b1, 8'h09, 1'b0},
                                {1'b0, 8'h00, 1'b1}, {1'b1, 8'h55, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            cyc(seq[i][9], seq[i][8:1], seq[i][0]);
            n_checks++;
            if (obs() !== expv()) $display("FAIL nop_err[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if (bus.cmd_err !== 1'b1) $display("FAIL cmd_err: got %b expected 1", bus.cmd_err);
        else n_pass++;
    endtask

    task automatic test_timeout();
        cyc(1'b1, 8'hAA, 1'b0);
        cyc(1'b1, 8'h03, 1'b0);
        for (int i = 0; i < 3 * TO_CYC; i++) begin
            cyc(1'b0, 8'h00, 1'b0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL timeout_idle[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
`ifdef RX_CMD_TIMEOUT_EN
            if (i == TO_CYC - 1) begin
                n_checks++;
                if (bus.timeout !== 1'b1 || bus.rf_wr_en !== 1'b0)
                    $display("FAIL timeout_pulse: got to=%b wr=%b expected to=1 wr=0", bus.timeout, bus.rf_wr_en);
                else n_pass++;
            end
`endif
        end
        // With the timeout the 0x7F is an unknown opcode; without it, it completes the write.
        cyc(1'b1, 8'h7F, 1'b0);
        n_checks++;
        if (obs() !== expv()) $display("FAIL timeout_next: got %h expected %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_reset_mid_command();
        cyc(1'b1, 8'hCC, 1'b0);
        cyc(1'b1, 8'h12, 1'b0);
        rst = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (obs() !== 22'h0) $display("FAIL mid_reset: got %h expected %h", obs(), 22'h0);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
        cyc(1'b1, 8'hBB, 1'b0);
        cyc(1'b1, 8'h01, 1'b0);
        n_checks++;
        if (obs() !== expv() || bus.rf_rd_en !== 1'b1 || bus.rf_addr !== 4'h1)
            $display("FAIL mid_reset_read: got %h expected %h", obs(), expv());
        else n_pass++;
        cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] ops [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        bit v, r;
        logic [7:0] d;
        for (int i = 0; i < 2000; i++) begin
            v = ($urandom_range(0, 99) < 60) && ((i % 250) < 225);
            d = ($urandom_range(0, 9) < 4) ? ops[$urandom_range(0, 3)] : 8'($urandom_range(0, 255));
            r = ($urandom_range(0, 99) < 15);
            cyc(v, d, r);
            n_checks++;
            if (obs() !== expv()) $display("FAIL random[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rsp_done = 1'b0;
        test_reset();
        test_write();
        test_read_overrun();
        test_alu_back_to_back();
        test_alu_nop_cmd_err();
        test_timeout();
        test_reset_mid_command();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
